execute: RTL
============

EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have inputs E_stat[0:3], E_icode[3:0], E_ifun[3:0], E_valA[63:0], E_valB[63:0], E_valC[63:0], E_dstE[3:0], E_dstM[3:0]: decoded instruction from E register.
REQ-004 SHALL have inputs m_stat[0:3] and W_stat[0:3]: status of the downstream memory and writeback stages, used for CC suppression.
REQ-005 SHALL have input M_bubble  1  insert a nop into the M register this cycle.
REQ-006 SHALL have registered outputs M_stat[0:3], M_icode[3:0], M_Cnd, M_valE[63:0], M_valA[63:0], M_dstE[3:0], M_dstM[3:0], consumed by the memory stage.
REQ-007 SHALL have combinational outputs e_valE[63:0], e_dstE[3:0], e_Cnd, for forwarding and branch-mispredict logic.

Function
REQ-008 Stat encoding SHALL be one-hot: AOK=1000, HLT=0100, ADR=0010, INS=0001; RNONE=4'hF; NOP icode=4'h1.
REQ-009 aluA SHALL be valA for rrmovq/cmov(2) and OPq(6); valC for irmovq(3), rmmovq(4), mrmovq(5); -8 for call(8) and pushq(A); +8 for ret(9) and popq(B); 0 otherwise.
REQ-010 aluB SHALL be valB for 4,5,6,8,9,A,B; 0 for 2,3 and all other icodes.
REQ-011 ALU function SHALL be E_ifun for OPq (0 add, 1 sub, 2 and, 3 xor); add for every other icode; OPq with ifun>3 yields e_valE=0 and no CC update.
REQ-012 e_valE SHALL be: add aluB+aluA; sub aluB-aluA; and aluB&aluA; xor aluB^aluA; 64-bit wrap, no carry out.
REQ-013 New flags: ZF=(e_valE==0); SF=e_valE[63]; OF for add = (aluA[63]==aluB[63])&&(e_valE[63]!=aluA[63]); for sub = (aluA[63]!=aluB[63])&&(e_valE[63]!=aluB[63]); 0 for and/xor.
REQ-014 CC register (ZF,SF,OF) SHALL update at posedge clk iff E_icode==6, ifun<=3, m_stat==AOK and W_stat==AOK.
REQ-015 e_Cnd SHALL come from the current (pre-update) CC and E_ifun: 0 true; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; ifun>6 false; e_Cnd is only meaningful for icodes 2 and 7.
REQ-016 e_dstE SHALL be RNONE when E_icode==2 and e_Cnd==0, else E_dstE.
REQ-017 At posedge clk with M_bubble=0, M register SHALL load E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM; latency from E inputs to M outputs is exactly one cycle.
REQ-018 At posedge clk with M_bubble=1, M register SHALL load M_icode=1, M_stat=AOK, M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=RNONE; the CC update decision in REQ-014 is independent of M_bubble.
REQ-019 E_stat other than AOK SHALL pass through to M_stat unchanged; it SHALL NOT block this cycle's CC update (only m_stat/W_stat do).

Reset
REQ-020 reset=1 SHALL immediately, without waiting for clk, force the M register to the bubble values of REQ-018.
REQ-021 reset=1 SHALL force CC to ZF=1, SF=0, OF=0.
REQ-022 While reset is high, clk edges SHALL have no effect; the first update occurs on the first posedge after deassertion.

Structure
REQ-023 icode values, stat codes, RNONE and ALU function codes SHALL live in a shared package, y86_pkg.
REQ-024 The combinational ALU plus flag generation SHALL be one sub-module, alu (aluA, aluB, alufun -> valE, ZF, SF, OF).
REQ-025 CC register, condition evaluation and the M pipeline register SHALL be in execute itself.

Verification
REQ-026 OPq sub, valA=5, valB=5, stat AOK -> e_valE=0; after the clock, ZF=1 SF=0 OF=0 and M_valE=0.
REQ-027 OPq add, valA=valB=0x7FFF_FFFF_FFFF_FFFF -> e_valE=0xFFFF_FFFF_FFFF_FFFE, then SF=1 OF=1 ZF=0; repeat with m_stat=ADR -> CC unchanged.
REQ-028 CC ZF=0 SF=1 OF=0, cmovle (icode 2, ifun 1), dstE=3 -> e_Cnd=1, M_dstE=3; with cmove (ifun 3) -> e_Cnd=0, M_dstE=F.
REQ-029 pushq, valB=0x100 -> M_valE=0xF8; popq, valB=0x100 -> M_valE=0x108; CC unchanged in both cases.
REQ-030 M_bubble=1 during a valid OPq -> M_icode=1, M_dstE=F, while CC still updates; asserting reset mid-cycle -> M outputs go to bubble values before the next clk.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg
//   Shared Y86-64 encodings for the execute stage: instruction codes,
//   one-hot status codes, the "no register" id, ALU function codes and the
//   branch/cmov condition codes, plus the condition evaluation helper.
//   There are no ports. Stat values are written as 4-bit literals whose
//   leftmost bit is AOK, so they drop straight into [0:3] stat buses.
package y86_pkg;

  // Instruction codes (upper nibble of the first instruction byte).
  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  // ALU operations; OPq selects one of these through its ifun.
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fn_e;

  // Condition selectors shared by jXX and cmovXX (their ifun field).
  typedef enum logic [3:0] {
    C_TRUE = 4'd0,
    C_LE   = 4'd1,
    C_L    = 4'd2,
    C_E    = 4'd3,
    C_NE   = 4'd4,
    C_GE   = 4'd5,
    C_G    = 4'd6
  } cond_e;

  // One-hot status codes.
  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  // Register id meaning "no destination".
  localparam logic [3:0] RNONE = 4'hF;

  // Stack-pointer step used by call/push (minus) and ret/pop (plus).
  localparam logic [63:0] STACK_DEC = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] STACK_INC = 64'h0000_0000_0000_0008;

  // Evaluate a jXX/cmovXX condition against a set of flags. Selectors
  // beyond the defined set evaluate false.
  function automatic logic condEval(input logic [3:0] ifun,
                                    input logic       zf,
                                    input logic       sf,
                                    input logic       of);
    logic lt;
    lt = sf ^ of;
    case (ifun)
      C_TRUE:  condEval = 1'b1;
      C_LE:    condEval = lt | zf;
      C_L:     condEval = lt;
      C_E:     condEval = zf;
      C_NE:    condEval = ~zf;
      C_GE:    condEval = ~lt;
      C_G:     condEval = ~lt & ~zf;
      default: condEval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_alu.sv
// alu
//   Purely combinational 64-bit ALU with condition-flag generation.
//   Ports:
//     aluA   in  64  first operand (the "source" / subtrahend side)
//     aluB   in  64  second operand (the "destination" side)
//     alufun in   2  operation, encoded as y86_pkg::alu_fn_e
//     valE   out 64  result, 64-bit wrap-around, no carry out
//     ZF     out  1  result is zero
//     SF     out  1  result is negative
//     OF     out  1  signed overflow (add/sub only)
module alu
  import y86_pkg::*;
(
  input  logic [63:0] aluA,
  input  logic [63:0] aluB,
  input  logic [1:0]  alufun,
  output logic [63:0] valE,
  output logic        ZF,
  output logic        SF,
  output logic        OF
);

  // The Y86 operand order is B op A, so subtraction computes aluB - aluA.
  // Overflow is judged from operand and result sign bits: for add the
  // operands agree in sign but the result does not; for sub the operands
  // differ in sign and the result has left the sign of aluB.
  always_comb begin
    valE = '0;
    OF   = 1'b0;
    case (alufun)
      ALU_ADD: begin
        valE = aluB + aluA;
        OF   = (aluA[63] == aluB[63]) && (valE[63] != aluA[63]);
      end
      ALU_SUB: begin
        valE = aluB - aluA;
        OF   = (aluA[63] != aluB[63]) && (valE[63] != aluB[63]);
      end
      ALU_AND: valE = aluB & aluA;
      ALU_XOR: valE = aluB ^ aluA;
      default: valE = '0;
    endcase
    ZF = (valE == 64'd0);
    SF = valE[63];
  end

endmodule

// File: rtl/execute.sv
// execute
//   Execute stage of a pipelined Y86-64 processor. Selects ALU operands
//   from the decoded instruction, runs the ALU, keeps the condition-code
//   register, evaluates jXX/cmovXX conditions and holds the M pipeline
//   register feeding the memory stage.
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     E_stat..E_dstM             instruction held in the E register
//     m_stat, W_stat             downstream status, gates CC updates
//     M_bubble                   load a nop into M this cycle
//     M_stat..M_dstM             registered M register contents
//     e_valE, e_dstE, e_Cnd      combinational forwarding / mispredict taps
module execute
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [0:3]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [63:0] E_valC,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [0:3]  m_stat,
  input  logic [0:3]  W_stat,
  input  logic        M_bubble,
  output logic [0:3]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_Cnd
);

  logic [63:0] aluA;
  logic [63:0] aluB;
  logic [1:0]  alufun;
  logic [63:0] aluValE;
  logic        aluZf;
  logic        aluSf;
  logic        aluOf;
  logic        isOpq;
  logic        opValid;
  logic        setCc;

  // Condition-code register.
  logic zf_q;
  logic sf_q;
  logic of_q;

  assign isOpq   = (E_icode == I_OPQ);
  assign opValid = isOpq && (E_ifun <= 4'd3);

  // Operand A: register value for moves and arithmetic, the immediate for
  // address/immediate forms, and a fixed +/-8 stack step for stack ops.
  always_comb begin
    aluA = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:              aluA = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: aluA = E_valC;
      I_CALL, I_PUSHQ:              aluA = STACK_DEC;
      I_RET, I_POPQ:                aluA = STACK_INC;
      default:                      aluA = '0;
    endcase
  end

  // Operand B: valB (base register or %rsp) wherever it participates;
  // moves pass A through by adding zero.
  always_comb begin
    aluB = '0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: aluB = E_valB;
      default:                                                   aluB = '0;
    endcase
  end

  // Only OPq chooses the operation; everything else is an address or
  // pass-through add.
  always_comb begin
    alufun = ALU_ADD;
    if (opValid) begin
      alufun = E_ifun[1:0];
    end
  end

  alu uAlu (
    .aluA   (aluA),
    .aluB   (aluB),
    .alufun (alufun),
    .valE   (aluValE),
    .ZF     (aluZf),
    .SF     (aluSf),
    .OF     (aluOf)
  );

  // An OPq with an undefined function produces zero rather than whatever
  // the ALU would compute for its truncated ifun.
  assign e_valE = (isOpq && !opValid) ? 64'd0 : aluValE;

  // Flags move only for a defined OPq while nothing downstream has faulted;
  // an exception in E itself does not hold them back.
  assign setCc = opValid && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

  // Conditions see the flags as they stood before this instruction.
  assign e_Cnd = condEval(E_ifun, zf_q, sf_q, of_q);

  // A cmov whose condition fails must not write its destination.
  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

  // CC register. Reset leaves ZF set so the initial state reads as "equal".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (setCc) begin
      zf_q <= aluZf;
      sf_q <= aluSf;
      of_q <= aluOf;
    end
  end

  // M pipeline register. Reset and bubble both load a nop; the bubble does
  // not interact with the CC decision above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || M_bubble) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule
